// File: rtl/tbman_arbiter.sv
// Two-requester round-robin arbiter in front of a single native slave port.
// One transfer in flight at a time: grant, issue, response.
module tbman_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_sel,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rv0_q, rv0_d;
    logic              rv1_q, rv1_d;

    logic idle;
    logic win1;
    logic any_req;

    // With both requesting, the side that did not own the last transfer wins
    assign idle    = (state_q == IDLE);
    assign any_req = m0_req | m1_req;
    assign win1    = m1_req & (~m0_req | ~last_q);

    assign m0_gnt = idle & m0_req & ~win1;
    assign m1_gnt = idle & win1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    owner_d = win1;
                    sel_d   = 1'b1;
                    write_d = win1 ? m1_write : m0_write;
                    addr_d  = win1 ? m1_addr  : m0_addr;
                    wdata_d = win1 ? m1_wdata : m0_wdata;
                end
            end
            ISSUE: begin
                state_d = RESP;
                rv0_d   = ~owner_q;
                rv1_d   = owner_q;
            end
            RESP: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    assign s_sel     = sel_q;
    assign s_write   = write_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign busy      = ~idle;

endmodule

// File: tb/tb_tbman_arbiter.sv
// Bench for tbman_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_tbman_arbiter;

    localparam int NC = 300;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_sel, s_write;
    logic [15:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        busy;

    int errs;
    int checks;

    tbman_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .s_sel(s_sel), .s_write(s_write), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave returns a fixed pattern of the address, one cycle after s_sel
    function automatic logic [31:0] rd_fn(input logic [15:0] a);
        return {16'hCAFE, 4'h0, a[15:4]};
    endfunction

    always @(posedge clk) begin
        if (s_sel && !s_write) s_rdata <= rd_fn(s_addr);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m0_req = 0; m1_req = 0; m0_write = 0; m1_write = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("rst_sel", s_sel, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_write},
            0);
        chk("rst_addr", s_addr, 0);
        chk("rst_wdata", s_wdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic r0, r1;
        logic g0, g1, sel, rv0, rv1, bsy;
    } vec_t;

    vec_t tv[15];

    // Reference model expectations per cycle of the random run
    logic        e_sel[NC+3];
    logic        e_wr[NC+3];
    logic [15:0] e_addr[NC+3];
    logic [31:0] e_wd[NC+3];
    logic        e_rv0[NC+3];
    logic        e_rv1[NC+3];
    logic        e_rd[NC+3];
    logic [31:0] e_rdat[NC+3];

    initial begin
        int sel_cnt, bl_cnt;
        int free_at;
        logic last, win, g0, g1, eb;
        errs = 0;
        checks = 0;
        rst_n = 1'b1;
        idle_in();

        tv[0]  = '{1,1, 1,0,0,0,0,0};
        tv[1]  = '{1,1, 0,0,1,0,0,1};
        tv[2]  = '{1,1, 0,0,0,1,0,1};
        tv[3]  = '{1,1, 0,1,0,0,0,0};
        tv[4]  = '{1,1, 0,0,1,0,0,1};
        tv[5]  = '{1,1, 0,0,0,0,1,1};
        tv[6]  = '{1,1, 1,0,0,0,0,0};
        tv[7]  = '{0,0, 0,0,1,0,0,1};
        tv[8]  = '{0,0, 0,0,0,1,0,1};
        tv[9]  = '{0,0, 0,0,0,0,0,0};
        tv[10] = '{0,1, 0,1,0,0,0,0};
        tv[11] = '{1,0, 0,0,1,0,0,1};
        tv[12] = '{0,0, 0,0,0,0,1,1};
        tv[13] = '{0,0, 0,0,0,0,0,0};
        tv[14] = '{0,0, 0,0,0,0,0,0};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            m0_req = tv[i].r0;
            m1_req = tv[i].r1;
            @(negedge clk);
            chk($sformatf("tv%0d_g0", i), m0_gnt, tv[i].g0);
            chk($sformatf("tv%0d_g1", i), m1_gnt, tv[i].g1);
            chk($sformatf("tv%0d_sel", i), s_sel, tv[i].sel);
            chk($sformatf("tv%0d_rv0", i), m0_rvalid, tv[i].rv0);
            chk($sformatf("tv%0d_rv1", i), m1_rvalid, tv[i].rv1);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
            next_cyc();
        end

        // Single read by m0
        m0_req = 1; m0_write = 0; m0_addr = 16'h0010;
        @(negedge clk);
        chk("rd_g0", m0_gnt, 1);
        next_cyc();
        m0_req = 0; m0_addr = 16'hFFFF;
        @(negedge clk);
        chk("rd_sel", {s_sel, s_write}, 2'b10);
        chk("rd_addr", s_addr, 16'h0010);
        next_cyc();
        @(negedge clk);
        chk("rd_rv", {m0_rvalid, m1_rvalid}, 2'b10);
        chk("rd_data", m0_rdata, 32'hCAFE0001);
        chk("rd_data1", m1_rdata, 32'hCAFE0001);
        next_cyc();

        // Write by m1 with inputs changed right after grant
        m1_req = 1; m1_write = 1; m1_addr = 16'h0000; m1_wdata = 32'h41;
        @(negedge clk);
        chk("wr_g1", {m0_gnt, m1_gnt}, 2'b01);
        next_cyc();
        m1_req = 0; m1_addr = 16'h1234; m1_wdata = 32'hDEAD;
        @(negedge clk);
        chk("wr_sel", {s_sel, s_write}, 2'b11);
        chk("wr_addr", s_addr, 0);
        chk("wr_wdata", s_wdata, 32'h41);
        next_cyc();
        @(negedge clk);
        chk("wr_rv", {m0_rvalid, m1_rvalid}, 2'b01);
        next_cyc();
        @(negedge clk);
        chk("wr_hold", s_wdata, 32'h41);
        chk("wr_idle", {busy, s_sel}, 0);
        next_cyc();

        // m0 completes, m1 granted, reset lands during ISSUE
        idle_in();
        m0_req = 1;
        next_cyc();
        m0_req = 0;
        next_cyc();
        next_cyc();
        m1_req = 1;
        @(negedge clk);
        chk("ri_g1", m1_gnt, 1);
        next_cyc();
        m1_req = 0;
        chk("ri_issue", s_sel, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ri_sel0", s_sel, 0);
        chk("ri_busy0", busy, 0);
        @(negedge clk);
        chk("ri_norv", {m0_rvalid, m1_rvalid}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("ri_norv2", {m0_rvalid, m1_rvalid}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("ri_first", {m0_gnt, m1_gnt}, 2'b10);
        next_cyc();
        idle_in();
        repeat (3) next_cyc();

        // m1 alone, continuous, ten transfers
        sel_cnt = 0;
        bl_cnt = 0;
        m1_req = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk($sformatf("m1c_g%0d", c), m1_gnt, (c % 3) == 0);
            chk($sformatf("m1c_b%0d", c), busy, (c % 3) != 0);
            if (s_sel) sel_cnt++;
            if (!busy) bl_cnt++;
            next_cyc();
        end
        m1_req = 0;
        chk("m1c_selcnt", sel_cnt, 10);
        chk("m1c_idlecnt", bl_cnt, 10);
        repeat (2) next_cyc();

        // Randomized run from reset against the transaction-level model
        do_reset();
        for (int i = 0; i < NC + 3; i++) begin
            e_sel[i] = 0; e_wr[i] = 0; e_addr[i] = 0; e_wd[i] = 0;
            e_rv0[i] = 0; e_rv1[i] = 0; e_rd[i] = 0; e_rdat[i] = 0;
        end
        free_at = 0;
        last = 1'b1;
        for (int c = 0; c < NC; c++) begin
            m0_req = ($urandom_range(0, 9) < 6);
            m1_req = ($urandom_range(0, 9) < 6);
            m0_write = $urandom_range(0, 1);
            m1_write = $urandom_range(0, 1);
            m0_addr = 16'($urandom);
            m1_addr = 16'($urandom);
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            g0 = 0;
            g1 = 0;
            eb = (c < free_at);
            if (!eb && (m0_req || m1_req)) begin
                win = (m0_req && m1_req) ? !last : m1_req;
                last = win;
                free_at = c + 3;
                g0 = !win;
                g1 = win;
                e_sel[c+1] = 1;
                e_wr[c+1] = win ? m1_write : m0_write;
                e_addr[c+1] = win ? m1_addr : m0_addr;
                e_wd[c+1] = win ? m1_wdata : m0_wdata;
                e_rv0[c+2] = !win;
                e_rv1[c+2] = win;
                e_rd[c+2] = !(win ? m1_write : m0_write);
                e_rdat[c+2] = rd_fn(win ? m1_addr : m0_addr);
            end
            @(negedge clk);
            chk("rnd_gnt", {m0_gnt, m1_gnt}, {g0, g1});
            chk("rnd_busy", busy, eb);
            chk("rnd_sel", s_sel, e_sel[c]);
            if (e_sel[c]) begin
                chk("rnd_wr", s_write, e_wr[c]);
                chk("rnd_addr", s_addr, e_addr[c]);
                if (e_wr[c]) chk("rnd_wd", s_wdata, e_wd[c]);
            end
            chk("rnd_rv", {m0_rvalid, m1_rvalid}, {e_rv0[c], e_rv1[c]});
            if (e_rd[c]) begin
                chk("rnd_rd0", m0_rdata, e_rdat[c]);
                chk("rnd_rd1", m1_rdata, e_rdat[c]);
            end
            next_cyc();
        end
        idle_in();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/tbman_arbiter.md
TBMAN_ARBITER -- requirements
Module: tbman_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, width of the native-port address.
REQ-002 Parameter: DATA_W, 32, width of the native-port write and read data.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports listed as:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 Ports SHALL be, for N in {0,1}:
- mN_req  in  1  requester N wants a transfer; held until granted.
- mN_write  in  1  1 = write, 0 = read; sampled in the grant cycle.
- mN_addr  in  ADDR_W  transfer address; sampled in the grant cycle.
- mN_wdata  in  DATA_W  write data; sampled in the grant cycle.
- mN_gnt  out  1  one-cycle pulse; the request was accepted this cycle.
- mN_rvalid  out  1  one-cycle pulse; the transfer completed and mN_rdata is valid.
- mN_rdata  out  DATA_W  read data, equal to s_rdata (both requesters).
- s_sel  out  1  native-port select, active high.
- s_write  out  1  native-port direction.
- s_addr  out  ADDR_W  native-port address.
- s_wdata  out  DATA_W  native-port write data.
- s_rdata  in  DATA_W  native-port read data; the slave registers it, so it is valid one cycle after s_sel.
- busy  out  1  high whenever state != IDLE.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, ISSUE, RESP; only one transfer SHALL be in flight at a time.
REQ-006 In IDLE, if any mN_req=1, the FSM SHALL:
- pick the winner (REQ-010);
- assert mN_gnt combinationally for the winner only, in that same cycle;
- latch the winner's write/addr/wdata and the owner ID on the clock edge;
- move to ISSUE.
REQ-007 In ISSUE: s_sel=1 and s_write/s_addr/s_wdata are driven from the latched registers; the next state SHALL be RESP unconditionally.
REQ-008 In RESP:
- s_sel=0;
- the owner's mN_rvalid=1 for exactly one cycle;
- the round-robin pointer SHALL update to the owner;
- the next state SHALL be IDLE.
REQ-009 Latency and throughput:
- gnt at cycle T, s_sel at T+1, rvalid at T+2;
- the next gnt is at T+3 at the earliest, giving a maximum throughput of one transfer per 3 cycles.
REQ-010 Arbitration SHALL be round-robin on last_owner: with both requesting, the requester other than last_owner wins; with one requesting, it wins regardless of pointer.
REQ-011 Each requester SHALL wait at most one other transfer before grant while it holds req.
REQ-012 Request drop rules:
- mN_req dropping before grant SHALL cancel that request without side effects.
- req still high in the cycle after gnt SHALL NOT be treated as a new request until the FSM returns to IDLE.
REQ-013 mN_rdata SHALL equal s_rdata at all times; writes still produce an rvalid completion pulse with rdata undefined-by-protocol.
REQ-014 s_write/s_addr/s_wdata SHALL hold their latched values outside ISSUE; the slave qualifies them only with s_sel.
REQ-015 mN_gnt and mN_rvalid SHALL never be high for both requesters in the same cycle; gnt SHALL never assert outside IDLE.

Reset
REQ-016 On rst_n=0, asynchronously and regardless of state (including mid-ISSUE/RESP):
- state=IDLE;
- s_sel=0, s_write=0, s_addr=0, s_wdata=0;
- owner=0, last_owner=1, so m0 wins the first contest;
- all gnt/rvalid=0, busy=0.
An in-flight transfer SHALL be abandoned with no rvalid.
REQ-017 After rst_n rises, the first grant SHALL be possible in the first clock edge's cycle that sees a request.

Verification
REQ-018 m0 read only, addr=0x0010, slave returns 0xCAFE0001 -> m0_gnt at T, s_sel=1/s_write=0/s_addr=0x0010 at T+1, m0_rvalid=1 with m0_rdata=0xCAFE0001 at T+2.
REQ-019 m0 and m1 request simultaneously from reset, both held -> m0, m1, m0 grants at T, T+3, T+6 (alternating); no cycle has both gnts.
REQ-020 m1 write addr=0x0000 wdata=0x00000041; m1 changes addr/wdata the cycle after gnt -> s_addr=0x0000 and s_wdata=0x00000041 during ISSUE.
REQ-021 m0 asserts req for one cycle while busy (FSM in ISSUE) and drops it -> no m0_gnt, no extra s_sel, FSM returns to IDLE and stays idle.
REQ-022 rst_n pulled low during ISSUE -> s_sel=0 immediately and no rvalid; after release, m0 and m1 request together -> m0 granted first.
REQ-023 Continuous m1-only requests over 10 transfers -> m1_gnt every 3 cycles; s_sel duty of 1-in-3 cycles; busy low only in the grant cycles.
